gpio_ctrl: RTL and testbench

//   Parametrised GPIO peripheral on the perips bus: NUM_PINS pins, each with
//   per-pin direction, output data, synchronised input and edge interrupt.

---
 rtl/gpio_pkg.sv | 39 +++
 rtl/gpio_sync.sv | 40 ++++
 rtl/gpio_ctrl.sv | 134 +++++++++++++
 tb/tb_gpio_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO peripheral: register map, widths and offset decode.
package gpio_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned MAX_PINS = 32;
    localparam int unsigned OFF_W    = 5;

    localparam logic [OFF_W-1:0] OFF_DIR        = 5'h00;
    localparam logic [OFF_W-1:0] OFF_DATA_OUT   = 5'h04;
    localparam logic [OFF_W-1:0] OFF_DATA_IN    = 5'h08;
    localparam logic [OFF_W-1:0] OFF_RISE_EN    = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_FALL_EN    = 5'h10;
    localparam logic [OFF_W-1:0] OFF_IRQ_STATUS = 5'h14;

    typedef enum logic [2:0] {
        REG_DIR        = 3'd0,
        REG_DATA_OUT   = 3'd1,
        REG_DATA_IN    = 3'd2,
        REG_RISE_EN    = 3'd3,
        REG_FALL_EN    = 3'd4,
        REG_IRQ_STATUS = 3'd5,
        REG_NONE       = 3'd6
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [OFF_W-1:0] off);
        reg_sel_e sel;
        case (off)
            OFF_DIR:        sel = REG_DIR;
            OFF_DATA_OUT:   sel = REG_DATA_OUT;
            OFF_DATA_IN:    sel = REG_DATA_IN;
            OFF_RISE_EN:    sel = REG_RISE_EN;
            OFF_FALL_EN:    sel = REG_FALL_EN;
            OFF_IRQ_STATUS: sel = REG_IRQ_STATUS;
            default:        sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs, synchronous active-low reset.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift chain: stage 0 captures the pad, each later stage takes its predecessor.
    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: bus register file, pad direction/data, input sync and
// sticky W1C edge interrupts ORed into irq_o.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned     NUM_PINS    = 16,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [REG_W-1:0] OUT_RST    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [REG_W-1:0]    addr_i,
    input  logic [REG_W-1:0]    data_i,
    output logic [REG_W-1:0]    data_o,
    output logic                ack_o,
    input  logic [NUM_PINS-1:0] io_in,
    output logic [NUM_PINS-1:0] io_out,
    output logic [NUM_PINS-1:0] io_oe,
    output logic                irq_o
);

    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] dout_q, dout_d;
    logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] prev_q, prev_d;
    logic                ack_q, ack_d;
    logic [REG_W-1:0]    data_q, data_d;

    logic [NUM_PINS-1:0] data_in_s;
    logic [NUM_PINS-1:0] w1c_s;
    logic [NUM_PINS-1:0] rise_s;
    logic [NUM_PINS-1:0] fall_s;
    logic [NUM_PINS-1:0] rd_pins_s;
    logic [REG_W-1:0]    rdata_s;
    logic                wr_s;
    logic                rd_s;
    reg_sel_e            sel_s;
    logic                unused_s;

    gpio_sync #(
        .WIDTH  (NUM_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (io_in),
        .q_o (data_in_s)
    );

    assign sel_s    = decode_offset(addr_i[OFF_W-1:0]);
    assign wr_s     = req_i & we_i;
    assign rd_s     = req_i & ~we_i;
    assign unused_s = ^{addr_i[REG_W-1:OFF_W], data_i};

    // Register writes and edge/status update; a fresh edge beats a same-cycle W1C.
    always_comb begin
        dir_d     = dir_q;
        dout_d    = dout_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_s     = {NUM_PINS{1'b0}};
        if (wr_s) begin
            case (sel_s)
                REG_DIR:        dir_d     = data_i[NUM_PINS-1:0];
                REG_DATA_OUT:   dout_d    = data_i[NUM_PINS-1:0];
                REG_RISE_EN:    rise_en_d = data_i[NUM_PINS-1:0];
                REG_FALL_EN:    fall_en_d = data_i[NUM_PINS-1:0];
                REG_IRQ_STATUS: w1c_s     = data_i[NUM_PINS-1:0];
                default:        w1c_s     = {NUM_PINS{1'b0}};
            endcase
        end else begin
            w1c_s = {NUM_PINS{1'b0}};
        end
        rise_s   = data_in_s & ~prev_q & rise_en_q;
        fall_s   = ~data_in_s & prev_q & fall_en_q;
        status_d = (status_q & ~w1c_s) | rise_s | fall_s;
        prev_d   = data_in_s;
    end

    // Read mux, zero-extended to the bus width; unmapped offsets read 0.
    always_comb begin
        case (sel_s)
            REG_DIR:        rd_pins_s = dir_q;
            REG_DATA_OUT:   rd_pins_s = dout_q;
            REG_DATA_IN:    rd_pins_s = data_in_s;
            REG_RISE_EN:    rd_pins_s = rise_en_q;
            REG_FALL_EN:    rd_pins_s = fall_en_q;
            REG_IRQ_STATUS: rd_pins_s = status_q;
            default:        rd_pins_s = {NUM_PINS{1'b0}};
        endcase
        rdata_s                = {REG_W{1'b0}};
        rdata_s[NUM_PINS-1:0]  = rd_pins_s;
        ack_d                  = req_i;
        if (rd_s) begin
            data_d = rdata_s;
        end else begin
            data_d = {REG_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q     <= {NUM_PINS{1'b0}};
            dout_q    <= OUT_RST[NUM_PINS-1:0];
            rise_en_q <= {NUM_PINS{1'b0}};
            fall_en_q <= {NUM_PINS{1'b0}};
            status_q  <= {NUM_PINS{1'b0}};
            prev_q    <= {NUM_PINS{1'b0}};
            ack_q     <= 1'b0;
            data_q    <= {REG_W{1'b0}};
        end else begin
            dir_q     <= dir_d;
            dout_q    <= dout_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign io_out = dout_q;
    assign io_oe  = dir_q;
    assign irq_o  = |status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: 16-pin and 8-pin instances share the bus,
// bus read data is scoreboarded through a queue of expected values.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_oe;
    logic        irq_o;
    logic [31:0] data8_o;
    logic        ack8_o;
    logic [7:0]  io_out8;
    logic [7:0]  io_oe8;
    logic        irq8_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] expv;

    always #5 clk = ~clk;

    gpio_ctrl #(.NUM_PINS(16), .SYNC_STAGES(2), .OUT_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .irq_o(irq_o)
    );

    gpio_ctrl #(.NUM_PINS(8), .SYNC_STAGES(2), .OUT_RST(32'h0)) dut8 (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data8_o), .ack_o(ack8_o), .io_in(io_in[7:0]),
        .io_out(io_out8), .io_oe(io_oe8), .irq_o(irq8_o)
    );

    // One single-cycle access; returns at the negedge where ack_o is due.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = wdata;
        @(negedge clk);
        req_i  = 1'b0;
        we_i   = 1'b0;
        data_i = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] offs [6];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        n_checks++; if (io_oe !== 16'h0) begin n_fail++; $display("FAIL reset_io_oe: got %h want 0", io_oe); end
        n_checks++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0", io_out); end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'h0);
            drive(1'b0, offs[i], 32'h0);
            expv = exp_q.pop_front();
            n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ack[%0d]: got %b want 1", i, ack_o); end
            n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL reset_rd[%0d]: got %h want %h", i, data_o, expv); end
        end
    endtask

    task automatic test_dir_dataout();
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h00, 32'h0000_00FF);
        expv = exp_q.pop_front();
        n_checks++; if (ack_o !== 1'b1 || data_o !== expv) begin n_fail++; $display("FAIL dir_wr_ack: got ack %b data %h want 1 %h", ack_o, data_o, expv); end
        n_checks++; if (io_oe !== 16'h00FF) begin n_fail++; $display("FAIL io_oe: got %h want 00ff", io_oe); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h04, 32'h0000_A5A5);
        expv = exp_q.pop_front();
        n_checks++; if (ack_o !== 1'b1 || data_o !== expv) begin n_fail++; $display("FAIL dout_wr_ack: got ack %b data %h want 1 %h", ack_o, data_o, expv); end
        n_checks++; if (io_out !== 16'hA5A5) begin n_fail++; $display("FAIL io_out: got %h want a5a5", io_out); end
        @(negedge clk);
        n_checks++; if (ack_o !== 1'b0 || data_o !== 32'h0) begin n_fail++; $display("FAIL ack_single: got ack %b data %h want 0 0", ack_o, data_o); end
        exp_q.push_back(32'h0000_00FF);
        exp_q.push_back(32'h0000_A5A5);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, (i == 0) ? 32'h00 : 32'h04, 32'h0);
            expv = exp_q.pop_front();
            n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL readback_ack[%0d]: got %b want 1", i, ack_o); end
            n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL readback[%0d]: got %h want %h", i, data_o, expv); end
        end
    endtask

    task automatic test_rise_irq();
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h0C, 32'h1);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL rise_en_wr: got %h want %h", data_o, expv); end
        io_in = 16'h0001;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (irq_o !== (k == 3)) begin n_fail++; $display("FAIL rise_latency[%0d]: got %b want %b", k, irq_o, (k == 3)); end
        end
        n_checks++; if (irq8_o !== 1'b1) begin n_fail++; $display("FAIL rise_irq8: got %b want 1", irq8_o); end
        exp_q.push_back(32'h1);
        drive(1'b0, 32'h14, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL rise_status: got %h want %h", data_o, expv); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h14, 32'h1);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL w1c_wr: got %h want %h", data_o, expv); end
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b want 0", irq_o); end
        exp_q.push_back(32'h0);
        drive(1'b0, 32'h14, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL w1c_status: got %h want %h", data_o, expv); end
    endtask

    task automatic test_w1c_collision();
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h10, 32'h2);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL fall_en_wr: got %h want %h", data_o, expv); end
        io_in = 16'h0003;
        repeat (4) @(negedge clk);
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL no_rise_irq: got %b want 0", irq_o); end
        io_in = 16'h0001;
        @(negedge clk);
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h14, 32'h2);
        io_in = 16'h0003;
        expv = exp_q.pop_front();
        n_checks++; if (ack_o !== 1'b1 || data_o !== expv) begin n_fail++; $display("FAIL collide_ack: got ack %b data %h want 1 %h", ack_o, data_o, expv); end
        n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL collide_irq: got %b want 1", irq_o); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h10, 32'h0);
        expv = exp_q.pop_front();
        exp_q.push_back(32'h2);
        drive(1'b0, 32'h14, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL sticky_status: got %h want %h", data_o, expv); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h14, 32'h2);
        expv = exp_q.pop_front();
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL collide_clear: got %b want 0", irq_o); end
    endtask

    task automatic test_num_pins();
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h00, 32'hFFFF_FFFF);
        expv = exp_q.pop_front();
        n_checks++; if (io_oe8 !== 8'hFF || io_oe !== 16'hFFFF) begin n_fail++; $display("FAIL np_io_oe: got %h/%h want ff/ffff", io_oe8, io_oe); end
        n_checks++; if (io_out8 !== 8'hA5) begin n_fail++; $display("FAIL np_io_out8: got %h want a5", io_out8); end
        exp_q.push_back(32'h0000_FFFF);
        drive(1'b0, 32'h00, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL np_dir16: got %h want %h", data_o, expv); end
        n_checks++; if (data8_o !== 32'h0000_00FF) begin n_fail++; $display("FAIL np_dir8: got %h want 000000ff", data8_o); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h1C, 32'hFFFF_FFFF);
        expv = exp_q.pop_front();
        exp_q.push_back(32'h0);
        drive(1'b0, 32'h1C, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (ack_o !== 1'b1 || ack8_o !== 1'b1) begin n_fail++; $display("FAIL unmapped_ack: got %b/%b want 1/1", ack_o, ack8_o); end
        n_checks++; if (data_o !== expv || data8_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h/%h want %h/0", data_o, data8_o, expv); end
        exp_q.push_back(32'h0);
        drive(1'b1, 32'h08, 32'hFFFF_FFFF);
        expv = exp_q.pop_front();
        exp_q.push_back(32'h3);
        drive(1'b0, 32'h08, 32'h0);
        expv = exp_q.pop_front();
        n_checks++; if (data_o !== expv || data8_o !== 32'h3) begin n_fail++; $display("FAIL data_in_ro: got %h/%h want %h/3", data_o, data8_o, expv); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst    = 1'b0;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h08;
        @(negedge clk);
        n_checks++; if (ack_o !== 1'b0 || ack8_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop_ack: got %b/%b want 0/0", ack_o, ack8_o); end
        req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL held_high_irq: got %b want 0", irq_o); end
        n_checks++; if (io_oe !== 16'h0) begin n_fail++; $display("FAIL rerst_io_oe: got %h want 0", io_oe); end
        req_i  = 1'b1;
        addr_i = 32'h08;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expv = exp_q.pop_front();
            n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ack_o); end
            n_checks++; if (data_o !== expv) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data_o, expv); end
        end
        req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ack_o !== 1'b0 || data_o !== 32'h0) begin n_fail++; $display("FAIL b2b_end: got ack %b data %h want 0 0", ack_o, data_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        io_in  = 16'h0;
        test_reset();
        test_dir_dataout();
        test_rise_irq();
        test_w1c_collision();
        test_num_pins();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
